// File: rtl/tex_texel_gather_if.sv
// rtl/tex_texel_gather_if.sv - header, memory response and sampler output bundle for tex_texel_gather
interface tex_texel_gather_if #(
    parameter int NUM_LANES   = 4,
    parameter int REQ_INFOW   = 1,
    parameter int BLEND_FRAC  = 8,
    parameter int FORMAT_BITS = 3
);
    logic                              hdr_valid;
    logic [FORMAT_BITS-1:0]            hdr_format;
    logic [NUM_LANES*2*BLEND_FRAC-1:0] hdr_blends;
    logic [NUM_LANES-1:0]              hdr_mask;
    logic                              hdr_point;
    logic [REQ_INFOW-1:0]              hdr_info;
    logic                              hdr_ready;

    logic                              mem_rsp_valid;
    logic [NUM_LANES*32-1:0]           mem_rsp_data;
    logic                              mem_rsp_ready;

    logic                              out_valid;
    logic [FORMAT_BITS-1:0]            out_format;
    logic [NUM_LANES*2*BLEND_FRAC-1:0] out_blends;
    logic [NUM_LANES*4*32-1:0]         out_data;
    logic [REQ_INFOW-1:0]              out_info;
    logic                              out_ready;

    modport master (
        output hdr_valid, hdr_format, hdr_blends, hdr_mask, hdr_point, hdr_info,
        input  hdr_ready,
        output mem_rsp_valid, mem_rsp_data,
        input  mem_rsp_ready,
        input  out_valid, out_format, out_blends, out_data, out_info,
        output out_ready
    );

    modport slave (
        input  hdr_valid, hdr_format, hdr_blends, hdr_mask, hdr_point, hdr_info,
        output hdr_ready,
        input  mem_rsp_valid, mem_rsp_data,
        output mem_rsp_ready,
        output out_valid, out_format, out_blends, out_data, out_info,
        input  out_ready
    );
endinterface

// File: rtl/tex_texel_gather.sv
// rtl/tex_texel_gather.sv - bilinear texel gather stage; TEX_GATHER_POINT_EN enables single-beat point requests
module tex_texel_gather #(
    parameter int NUM_LANES   = 4,
    parameter int REQ_INFOW   = 1,
    parameter int BLEND_FRAC  = 8,
    parameter int FORMAT_BITS = 3
) (
    input  logic              clk,
    input  logic              reset,
    tex_texel_gather_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GATHER, FULL} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                cnt_q;
    logic [NUM_LANES-1:0]      mask_q;
    logic [FORMAT_BITS-1:0]    format_q;
    logic [NUM_LANES*2*BLEND_FRAC-1:0] blends_q;
    logic [REQ_INFOW-1:0]      info_q;
    logic [NUM_LANES*4*32-1:0] data_q;
    logic                      hdr_ready_c, mem_ready_c, out_valid_c;
    logic                      hdr_fire, beat_fire, last_beat, point_q;

    assign hdr_fire  = bus.hdr_valid && hdr_ready_c;
    assign beat_fire = bus.mem_rsp_valid && mem_ready_c;

`ifdef TEX_GATHER_POINT_EN
    assign last_beat = point_q || (cnt_q == 2'd3);
`else
    logic unused_point;
    assign unused_point = bus.hdr_point;
    assign last_beat    = (cnt_q == 2'd3);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.hdr_valid) state_d = GATHER;
            GATHER:  if (beat_fire && last_beat) state_d = FULL;
            FULL:    if (bus.out_ready) state_d = bus.hdr_valid ? GATHER : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hdr_ready_c = 1'b0;
        mem_ready_c = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE:    hdr_ready_c = 1'b1;
            GATHER:  mem_ready_c = 1'b1;
            FULL: begin
                out_valid_c = 1'b1;
                hdr_ready_c = bus.out_ready;
            end
            default: ;
        endcase
    end

    // Header fields go straight to the output registers: a new header can only
    // land while the previous quad is being released, so out_* stay stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= 2'd0;
            mask_q   <= '0;
            point_q  <= 1'b0;
            format_q <= '0;
            blends_q <= '0;
            info_q   <= '0;
            data_q   <= '0;
        end else begin
            if (hdr_fire) begin
                cnt_q    <= 2'd0;
                mask_q   <= bus.hdr_mask;
`ifdef TEX_GATHER_POINT_EN
                point_q  <= bus.hdr_point;
`else
                point_q  <= 1'b0;
`endif
                format_q <= bus.hdr_format;
                blends_q <= bus.hdr_blends;
                info_q   <= bus.hdr_info;
            end
            if (beat_fire) begin
                cnt_q <= last_beat ? 2'd0 : cnt_q + 2'd1;
                for (int i = 0; i < NUM_LANES; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        if (point_q || (2'(j) == cnt_q))
                            data_q[(i*4+j)*32 +: 32] <= bus.mem_rsp_data[i*32 +: 32] & {32{mask_q[i]}};
                    end
                end
            end
        end
    end

    assign bus.hdr_ready     = hdr_ready_c;
    assign bus.mem_rsp_ready = mem_ready_c;
    assign bus.out_valid     = out_valid_c;
    assign bus.out_format    = format_q;
    assign bus.out_blends    = blends_q;
    assign bus.out_info      = info_q;
    assign bus.out_data      = data_q;
endmodule

// File: tb/tb_tex_texel_gather.sv
// tb/tb_tex_texel_gather.sv - directed and randomized checks of tex_texel_gather against a request-level model
module tb_tex_texel_gather;
    localparam int NL = 4, IW = 1, BF = 8, FB = 3;
    localparam int DW = NL*4*32;
    localparam int MW = NL*32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tex_texel_gather_if #(.NUM_LANES(NL), .REQ_INFOW(IW), .BLEND_FRAC(BF), .FORMAT_BITS(FB)) bus ();
    tex_texel_gather #(.NUM_LANES(NL), .REQ_INFOW(IW), .BLEND_FRAC(BF), .FORMAT_BITS(FB))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // request-level model: a request is gathering until it has its beats, then full until taken
    bit              m_gather, m_full;
    int              m_need;
    logic [MW-1:0]   m_beats[$];
    logic [NL-1:0]   m_mask;
    logic [FB-1:0]   e_format;
    logic [NL*2*BF-1:0] e_blends;
    logic [IW-1:0]   e_info;
    logic [DW-1:0]   e_data;
    bit              last_hh, last_bh;

    function automatic logic [DW-1:0] assemble();
        logic [DW-1:0] r = '0;
        logic [MW-1:0] b;
        for (int i = 0; i < NL; i++)
            for (int j = 0; j < 4; j++) begin
                b = m_beats[(m_need == 1) ? 0 : j];
                if (m_mask[i]) r[(i*4+j)*32 +: 32] = b[i*32 +: 32];
            end
        return r;
    endfunction

    task automatic step();
        bit hh, bh, oh, exp_hr;
        #1;
        exp_hr = !m_gather && (!m_full || bus.out_ready);
        check("out_valid", bus.out_valid, m_full);
        check("hdr_ready", bus.hdr_ready, exp_hr);
        check("mem_rsp_ready", bus.mem_rsp_ready, m_gather);
        if (m_full) begin
            check("out_data", bus.out_data, e_data);
            check("out_format", bus.out_format, e_format);
            check("out_blends", bus.out_blends, e_blends);
            check("out_info", bus.out_info, e_info);
        end
        hh = bus.hdr_valid && exp_hr;
        bh = bus.mem_rsp_valid && m_gather;
        oh = m_full && bus.out_ready;
        if (oh) m_full = 0;
        if (bh) begin
            m_beats.push_back(bus.mem_rsp_data);
            if (m_beats.size() == m_need) begin
                e_data   = assemble();
                m_gather = 0;
                m_full   = 1;
            end
        end
        if (hh) begin
            m_mask   = bus.hdr_mask;
            e_format = bus.hdr_format;
            e_blends = bus.hdr_blends;
            e_info   = bus.hdr_info;
`ifdef TEX_GATHER_POINT_EN
            m_need   = bus.hdr_point ? 1 : 4;
`else
            m_need   = 4;
`endif
            m_beats.delete();
            m_gather = 1;
        end
        last_hh = hh;
        last_bh = bh;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_hdr(input logic [NL-1:0] mask, input logic point);
        bus.hdr_format = FB'($urandom);
        bus.hdr_blends = {$urandom, $urandom};
        bus.hdr_mask   = mask;
        bus.hdr_point  = point;
        bus.hdr_info   = IW'($urandom);
    endtask

    task automatic do_reset();
        bus.hdr_valid     = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.out_ready     = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_mem_ready", bus.mem_rsp_ready, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_info", bus.out_info, 0);
        m_gather = 0;
        m_full   = 0;
        m_beats.delete();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hdr_ready", bus.hdr_ready, 1);
    endtask

    task automatic finish_quad(input string tag);
        for (int k = 0; k < 20 && !bus.out_valid; k++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        bus.mem_rsp_valid = 1'b0;
        check({tag, "_done"}, bus.out_valid, 1);
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    logic [DW-1:0] snap;
    logic [MW-1:0] tmp;

    initial begin
        reset = 1'b0;
        bus.hdr_valid = 1'b0; bus.hdr_point = 1'b0; bus.hdr_mask = '0;
        bus.hdr_format = '0; bus.hdr_blends = '0; bus.hdr_info = '0;
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0; bus.out_ready = 1'b0;
        do_reset();

        // back-to-back beats: out_valid five cycles after the header
        rand_hdr(4'hf, 1'b0);
        bus.hdr_info  = 1'b1;
        bus.hdr_valid = 1'b1;
        step();
        check("A_hdr_taken", last_hh, 1);
        bus.hdr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tmp = 32'h11111111 * (k + 1);
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = {4{tmp[31:0]}};
            step();
        end
        bus.mem_rsp_valid = 1'b0;
        check("A_lat5", bus.out_valid, 1);
        check("A_data", bus.out_data, {4{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}});
        check("A_info", bus.out_info, 1);
        release_out();

        // two idle cycles after each beat: six extra cycles of latency
        rand_hdr(4'hf, 1'b0);
        bus.hdr_valid = 1'b1;
        step();
        bus.hdr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) check("B_not_early", bus.out_valid, 0);
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            step();
            bus.mem_rsp_valid = 1'b0;
            if (k < 3)
                repeat (2) begin
                    check("B_ready_gap", bus.mem_rsp_ready, 1);
                    step();
                end
        end
        check("B_lat11", bus.out_valid, 1);

        // stall in FULL with a pending header and beat, then mask 0101 request
        snap = bus.out_data;
        rand_hdr(4'b0101, 1'b0);
        bus.hdr_valid     = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
        repeat (10) begin
            step();
            check("C_hdr_ready", bus.hdr_ready, 0);
            check("C_mem_ready", bus.mem_rsp_ready, 0);
            check("C_stable", bus.out_data, snap);
        end
        bus.out_ready = 1'b1;
        step();
        check("C_hdr_same_cycle", last_hh, 1);
        bus.out_ready = 1'b0;
        bus.hdr_valid = 1'b0;
        check("C_gather_next", bus.mem_rsp_ready, 1);
        finish_quad("D");
        check("D_lane1_zero", bus.out_data[1*128 +: 128], 0);
        check("D_lane3_zero", bus.out_data[3*128 +: 128], 0);
        release_out();

        // reset after two beats discards the partial quad
        rand_hdr(4'hf, 1'b0);
        bus.hdr_valid = 1'b1;
        step();
        bus.hdr_valid = 1'b0;
        repeat (2) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        do_reset();
        rand_hdr(4'hf, 1'b0);
        bus.hdr_valid = 1'b1;
        step();
        bus.hdr_valid = 1'b0;
        finish_quad("E");
        release_out();

`ifdef TEX_GATHER_POINT_EN
        rand_hdr(4'hf, 1'b1);
        bus.hdr_valid = 1'b1;
        step();
        bus.hdr_valid     = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = {4{32'hABCD1234}};
        step();
        bus.mem_rsp_valid = 1'b0;
        check("F_point_lat2", bus.out_valid, 1);
        check("F_point_data", bus.out_data, {16{32'hABCD1234}});
        release_out();
        bus.hdr_point = 1'b0;
`endif

        // randomized traffic; producers hold valid and payload until accepted
        last_hh = 0;
        last_bh = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!bus.hdr_valid || last_hh) begin
                bus.hdr_valid = 1'($urandom_range(0, 1));
                rand_hdr(NL'($urandom), 1'($urandom_range(0, 3) == 0));
            end
            if (!bus.mem_rsp_valid || last_bh) begin
                bus.mem_rsp_valid = ($urandom_range(0, 3) != 0);
                bus.mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
